sprite_match_unit: RTL and testbench
====================================

# sprite_match_unit

Read side of the per-line sprite store. The OAM scan writes up to NSLOT matching sprites (X, OAM index, row-in-tile) during mode 2. During mode 3 this block compares every valid slot's X against the pixel counter and stalls the pixel pipe on a hit. It then hands the winning slot to the sprite fetcher through a req/done handshake and retires the slot when the fetch completes.

## Interface
Parameters:
- NSLOT, 10, number of sprite slots per line
- XW, 8, width of X position and pixel counter

Ports:
- clk1  in  1  system clock; all state changes on rising edge
- nreset_video  in  1  reset, synchronous, active-low
- line_start  in  1  one-cycle pulse at line begin; invalidates all slots
- wr_en  in  1  scan write strobe, one slot per cycle
- wr_x  in  XW  sprite X of write
- wr_idx  in  6  OAM index of write
- wr_line  in  4  row within sprite (0..15) of write
- render_en  in  1  mode 3 active
- px  in  XW  current pixel X counter
- stall  out  1  combinational: render_en && any valid slot has x == px
- fetch_req  out  1  registered request to sprite fetcher
- fetch_idx  out  6  latched OAM index, valid while fetch_req
- fetch_line  out  4  latched row, valid while fetch_req
- fetch_done  in  1  one-cycle pulse from fetcher: sprite pixels merged
- slot_count  out  4  number of slots written this line (0..NSLOT)

## Operation
- Storage: NSLOT entries {valid, x, idx, line}; write pointer equals slot_count.
- Write: wr_en && !render_en && slot_count < NSLOT → entry[slot_count] loaded and marked valid, slot_count+1. A write with slot_count == NSLOT, or during render_en, is dropped with no state change.
- line_start: all valid cleared, slot_count := 0, FSM → IDLE, fetch_req := 0. It overrides a same-cycle wr_en, which is dropped, and a same-cycle fetch_done.
- Match: hit[i] = valid[i] && x[i] == px, over the full XW bits with no offset. The winner is the lowest-numbered hit slot (earliest scanned), found with a fixed priority encoder.
- FSM states:
  - IDLE: render_en && any hit → latch winner slot number, idx and line; fetch_req := 1; → BUSY.
  - BUSY: fetch_req held 1 and latched fields stable.
    - fetch_done → valid[latched slot] := 0, fetch_req := 0, → IDLE.
    - render_en falling → abort to IDLE, fetch_req := 0, slot stays valid.
- fetch_done in IDLE is ignored.
- Several sprites at the same X are serviced one at a time in slot order. stall stays high until the last one is retired.
- slot_count never decrements on retire; only line_start or reset clears it.

## Timing
- Reset (nreset_video low at an edge): all valid = 0, slot_count = 0, FSM = IDLE, fetch_req = 0, fetch_idx = 0, fetch_line = 0. stall = 0 as a consequence.
- stall: zero-latency combinational from px/valid/render_en, so the pixel counter does not advance past a hit.
- fetch_req rises one edge after the first cycle stall is high in IDLE.
- Retire: the slot is cleared at the fetch_done edge. Any next same-X slot raises fetch_req one edge later. A minimum of one IDLE cycle separates consecutive requests.
- Write to visible slot: a slot written at edge N is compare-visible in cycle N+1.

## Configuration
- SPRITE_MATCH_OVF_EN defined:
  - adds output ovf (1 bit), a sticky flag set when a write is dropped because slot_count == NSLOT;
  - ovf is cleared by line_start or reset, and its set is registered (visible the cycle after the dropped write).
- Undefined: no ovf port; dropped writes are silent.

## Test plan
- Reset/clear: hold nreset_video low 2 cycles with render_en=1, px=0 → fetch_req=0, stall=0, slot_count=0. Pulse line_start after writes → slot_count=0, stall=0 at px of a former entry.
- Single sprite: write x=8, idx=5, line=3; render_en=1, sweep px from 0.
  - At px=8: stall=1 same cycle.
  - Next cycle: fetch_req=1, fetch_idx=5, fetch_line=3.
  - fetch_done after 6 cycles → fetch_req=0, stall=0 following cycle.
- Same-X priority: slots 0..2 written at x=20 with idx 7, 2, 9 → requests issued in order idx 7, 2, 9; stall high throughout, low after third fetch_done.
- Overflow: 11 writes → slot_count=10, 11th entry never matches. With SPRITE_MATCH_OVF_EN, ovf=1 until line_start.
- Abort: in BUSY, drop render_en → fetch_req=0. Re-raise render_en at same px → new request for the same slot.
- Collisions:
  - line_start coinciding with wr_en → slot_count=0 next cycle;
  - fetch_done pulsed in IDLE → no state change;
  - write during render_en → dropped.

Source files
------------

// File: rtl/sprite_match_unit_if.sv
// Bus between the sprite store and its scan / render / fetcher neighbours.
// SPRITE_MATCH_OVF_EN adds the sticky overflow flag ovf.
interface sprite_match_unit_if #(
  parameter int unsigned XW = 8
);
  logic          line_start;
  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [5:0]    wr_idx;
  logic [3:0]    wr_line;
  logic          render_en;
  logic [XW-1:0] px;
  logic          stall;
  logic          fetch_req;
  logic [5:0]    fetch_idx;
  logic [3:0]    fetch_line;
  logic          fetch_done;
  logic [3:0]    slot_count;
`ifdef SPRITE_MATCH_OVF_EN
  logic          ovf;

  modport master (
    output line_start, wr_en, wr_x, wr_idx, wr_line, render_en, px, fetch_done,
    input  stall, fetch_req, fetch_idx, fetch_line, slot_count, ovf
  );
  modport slave (
    input  line_start, wr_en, wr_x, wr_idx, wr_line, render_en, px, fetch_done,
    output stall, fetch_req, fetch_idx, fetch_line, slot_count, ovf
  );
`else
  modport master (
    output line_start, wr_en, wr_x, wr_idx, wr_line, render_en, px, fetch_done,
    input  stall, fetch_req, fetch_idx, fetch_line, slot_count
  );
  modport slave (
    input  line_start, wr_en, wr_x, wr_idx, wr_line, render_en, px, fetch_done,
    output stall, fetch_req, fetch_idx, fetch_line, slot_count
  );
`endif
endinterface

// File: rtl/sprite_match_unit.sv
// Per-line sprite slot store: X compare against the pixel counter, stall, and fetch hand-off.
// Optional sticky overflow flag under SPRITE_MATCH_OVF_EN.
module sprite_match_unit #(
  parameter int unsigned NSLOT = 10,
  parameter int unsigned XW    = 8
) (
  input  logic clk1,
  input  logic nreset_video,
  sprite_match_unit_if.slave bus
);
  localparam int unsigned IDXW  = 6;
  localparam int unsigned LINEW = 4;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned SLOTW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef struct packed {
    logic             valid;
    logic [XW-1:0]    x;
    logic [IDXW-1:0]  idx;
    logic [LINEW-1:0] line;
  } slot_t;

  typedef enum logic {IDLE, BUSY} state_t;

  slot_t            slot_q [NSLOT];
  slot_t            slot_d [NSLOT];
  state_t           state_q, state_d;
  logic [CNTW-1:0]  slot_count_q, slot_count_d;
  logic [SLOTW-1:0] cur_slot_q, cur_slot_d;
  logic             fetch_req_q, fetch_req_d;
  logic [IDXW-1:0]  fetch_idx_q, fetch_idx_d;
  logic [LINEW-1:0] fetch_line_q, fetch_line_d;
`ifdef SPRITE_MATCH_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NSLOT-1:0] hit;
  logic [SLOTW-1:0] win_slot;
  logic             any_hit;

  // Match every slot against the pixel counter; lowest slot number wins.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLOT; i++) begin
      hit[i] = slot_q[i].valid && (slot_q[i].x == bus.px);
    end
  end

  always_comb begin
    win_slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (hit[i]) win_slot = SLOTW'(i);
    end
  end

  assign any_hit   = |hit;
  assign bus.stall = bus.render_en && any_hit;

  always_comb begin
    slot_d       = slot_q;
    state_d      = state_q;
    slot_count_d = slot_count_q;
    cur_slot_d   = cur_slot_q;
    fetch_req_d  = fetch_req_q;
    fetch_idx_d  = fetch_idx_q;
    fetch_line_d = fetch_line_q;
`ifdef SPRITE_MATCH_OVF_EN
    ovf_d        = ovf_q;
`endif

    if (bus.line_start) begin
      for (int i = 0; i < NSLOT; i++) slot_d[i].valid = 1'b0;
      slot_count_d = '0;
      state_d      = IDLE;
      fetch_req_d  = 1'b0;
`ifdef SPRITE_MATCH_OVF_EN
      ovf_d        = 1'b0;
`endif
    end else begin
      // Scan writes only land outside mode 3 and while a free slot remains.
      if (bus.wr_en && !bus.render_en) begin
        if (slot_count_q < CNTW'(NSLOT)) begin
          slot_d[SLOTW'(slot_count_q)] = '{valid: 1'b1, x: bus.wr_x,
                                           idx: bus.wr_idx, line: bus.wr_line};
          slot_count_d = slot_count_q + CNTW'(1);
        end
`ifdef SPRITE_MATCH_OVF_EN
        else begin
          ovf_d = 1'b1;
        end
`endif
      end

      unique case (state_q)
        IDLE: begin
          if (bus.render_en && any_hit) begin
            cur_slot_d   = win_slot;
            fetch_idx_d  = slot_q[win_slot].idx;
            fetch_line_d = slot_q[win_slot].line;
            fetch_req_d  = 1'b1;
            state_d      = BUSY;
          end
        end
        BUSY: begin
          if (bus.fetch_done) begin
            slot_d[cur_slot_q].valid = 1'b0;
            fetch_req_d = 1'b0;
            state_d     = IDLE;
          end else if (!bus.render_en) begin
            fetch_req_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!nreset_video) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
      state_q      <= IDLE;
      slot_count_q <= '0;
      cur_slot_q   <= '0;
      fetch_req_q  <= 1'b0;
      fetch_idx_q  <= '0;
      fetch_line_q <= '0;
`ifdef SPRITE_MATCH_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= slot_d[i];
      state_q      <= state_d;
      slot_count_q <= slot_count_d;
      cur_slot_q   <= cur_slot_d;
      fetch_req_q  <= fetch_req_d;
      fetch_idx_q  <= fetch_idx_d;
      fetch_line_q <= fetch_line_d;
`ifdef SPRITE_MATCH_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_idx  = fetch_idx_q;
  assign bus.fetch_line = fetch_line_q;
  assign bus.slot_count = slot_count_q;
`ifdef SPRITE_MATCH_OVF_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_sprite_match_unit.sv
// Scoreboarded random bench for sprite_match_unit against a slot-list reference model.
module tb_sprite_match_unit;
  localparam int unsigned NSLOT = 10;
  localparam int unsigned XW    = 8;

  logic clk1 = 1'b0;
  logic nreset_video;
  always #5 clk1 = ~clk1;

  sprite_match_unit_if #(.XW(XW)) bus ();
  sprite_match_unit #(.NSLOT(NSLOT), .XW(XW)) dut (
    .clk1(clk1), .nreset_video(nreset_video), .bus(bus)
  );

  typedef struct { int idx; int line; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: the list of slots written this line.
  bit m_valid [NSLOT];
  int m_x     [NSLOT];
  int m_idx   [NSLOT];
  int m_line  [NSLOT];
  int m_count;
  bit m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input int p);
    for (int i = 0; i < NSLOT; i++)
      if (m_valid[i] && m_x[i] == p) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSLOT; i++) m_valid[i] = 0;
    m_count = 0;
    m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic wr(input int x, input int idx, input int line);
    bus.wr_en = 1'b1;
    bus.wr_x = XW'(x);
    bus.wr_idx = 6'(idx);
    bus.wr_line = 4'(line);
    if (!bus.render_en) begin
      if (m_count < NSLOT) begin
        m_valid[m_count] = 1; m_x[m_count] = x; m_idx[m_count] = idx; m_line[m_count] = line;
        m_count++;
      end else begin
        m_ovf = 1;
      end
    end
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic clear_line(input bit with_wr);
    bus.line_start = 1'b1;
    if (with_wr) begin
      bus.wr_en = 1'b1;
      bus.wr_x = XW'($urandom_range(0, 47));
    end
    tick();
    bus.line_start = 1'b0;
    bus.wr_en = 1'b0;
    model_clear();
    chk("clear_count", bus.slot_count, 0);
  endtask

  task automatic check_ovf();
`ifdef SPRITE_MATCH_OVF_EN
    chk("ovf", bus.ovf, 32'(m_ovf));
`endif
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (bus.fetch_req !== 1'b1 && k < 4) begin
      tick();
      k++;
    end
    chk({name, "_latency"}, k, 1);
  endtask

  // Resolve every hit at pixel p, one fetch at a time, in slot order.
  task automatic service_px(input int p, input bit rnd);
    int w;
    int guard = 0;
    #1;
    w = winner(p);
    chk("stall", bus.stall, 32'(w >= 0));
    while (w >= 0 && guard < NSLOT + 2) begin
      guard++;
      exp_q.push_back('{m_idx[w], m_line[w]});
      wait_req("req");
      if (rnd && $urandom_range(0, 5) == 0) begin
        bus.render_en = 1'b0;
        tick();
        chk("abort_req", bus.fetch_req, 0);
        chk("abort_stall", bus.stall, 0);
        bus.render_en = 1'b1;
        #1;
        chk("abort_restall", bus.stall, 1);
        exp_q.push_back('{m_idx[w], m_line[w]});
        wait_req("rereq");
      end
      repeat (rnd ? $urandom_range(0, 6) : 6) tick();
      chk("busy_hold", bus.fetch_req, 1);
      chk("busy_stall", bus.stall, 1);
      bus.fetch_done = 1'b1;
      tick();
      bus.fetch_done = 1'b0;
      m_valid[w] = 0;
      #1;
      chk("retire_req", bus.fetch_req, 0);
      w = winner(p);
      chk("stall_after", bus.stall, 32'(w >= 0));
    end
  endtask

  task automatic render_line(input int max_px, input bit rnd);
    bus.render_en = 1'b1;
    for (int p = 0; p <= max_px; p++) begin
      bus.px = XW'(p);
      service_px(p, rnd);
      if (rnd && $urandom_range(0, 15) == 0) begin
        bus.fetch_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
        chk("idle_done_req", bus.fetch_req, 0);
        chk("idle_done_count", bus.slot_count, 32'(m_count));
      end
      tick();
    end
    bus.render_en = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every new request must match the oldest expected one.
  logic prev_req = 1'b0;
  always @(negedge clk1) begin
    exp_t e;
    if (nreset_video === 1'b1 && bus.fetch_req === 1'b1 && prev_req !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_req: idx %0d line %0d with none expected at %0t",
                 bus.fetch_idx, bus.fetch_line, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.fetch_idx !== 6'(e.idx) || bus.fetch_line !== 4'(e.line)) begin
          errors++;
          $display("FAIL fetch_fields: got idx %0d line %0d expected idx %0d line %0d at %0t",
                   bus.fetch_idx, bus.fetch_line, e.idx, e.line, $time);
        end
      end
    end
    prev_req = bus.fetch_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.line_start = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_x = '0;
    bus.wr_idx = '0;
    bus.wr_line = '0;
    bus.fetch_done = 1'b0;
    bus.render_en = 1'b1;
    bus.px = '0;
    nreset_video = 1'b0;
    model_clear();
    repeat (2) tick();
    chk("rst_req", bus.fetch_req, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_count", bus.slot_count, 0);
    chk("rst_idx", bus.fetch_idx, 0);
    chk("rst_line", bus.fetch_line, 0);
    check_ovf();
    nreset_video = 1'b1;
    bus.render_en = 1'b0;
    tick();

    // Single sprite.
    wr(8, 5, 3);
    chk("single_count", bus.slot_count, 1);
    render_line(12, 0);

    // line_start invalidates a former entry.
    clear_line(0);
    wr(30, 1, 1);
    clear_line(0);
    bus.render_en = 1'b1;
    bus.px = XW'(30);
    #1;
    chk("cleared_stall", bus.stall, 0);
    bus.render_en = 1'b0;
    tick();

    // Same-X priority in slot order.
    wr(20, 7, 0);
    wr(20, 2, 1);
    wr(20, 9, 2);
    render_line(24, 0);

    // Overflow: the 11th write is dropped.
    clear_line(0);
    for (int i = 0; i < 11; i++) wr(40 + i, i, i);
    chk("ovf_count", bus.slot_count, 10);
    check_ovf();
    render_line(52, 0);
    check_ovf();
    clear_line(0);
    check_ovf();

    // Write during render is dropped.
    bus.render_en = 1'b1;
    wr(60, 3, 3);
    bus.render_en = 1'b0;
    chk("render_wr_count", bus.slot_count, 0);

    // line_start wins over a same-cycle write.
    clear_line(1);

    // fetch_done in IDLE is ignored; the slot is still serviced later.
    wr(5, 4, 4);
    bus.render_en = 1'b1;
    bus.px = '0;
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
    chk("idle_done_req0", bus.fetch_req, 0);
    chk("idle_done_cnt0", bus.slot_count, 1);
    render_line(8, 0);

    // Abort and re-request of the same slot.
    clear_line(0);
    wr(10, 11, 6);
    bus.render_en = 1'b1;
    bus.px = XW'(10);
    #1;
    exp_q.push_back('{11, 6});
    wait_req("abort1");
    bus.render_en = 1'b0;
    tick();
    chk("abort_dir_req", bus.fetch_req, 0);
    bus.render_en = 1'b1;
    #1;
    chk("abort_dir_stall", bus.stall, 1);
    exp_q.push_back('{11, 6});
    wait_req("abort2");
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
    m_valid[0] = 0;
    #1;
    chk("abort_dir_retire", bus.fetch_req, 0);
    chk("abort_dir_stall0", bus.stall, 0);
    bus.render_en = 1'b0;
    tick();

    // Random lines.
    for (int l = 0; l < 15; l++) begin
      clear_line(1'($urandom_range(0, 1)));
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++)
        wr($urandom_range(0, 47), $urandom_range(0, 63), $urandom_range(0, 15));
      chk("rnd_count", bus.slot_count, 32'(m_count));
      check_ovf();
      render_line(47, 1);
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
